// File: rtl/sram_result_checker_if.sv
// Controller-to-checker bus: read strobe, clear, address/pattern and the SRAM read data.
interface sram_result_checker_if #(
    parameter int ADDR_BITS = 20,
    parameter int DATA_BITS = 16
);
    logic                 enable;
    logic                 clear;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] expected;
    logic [DATA_BITS-1:0] read_data;

    modport master (output enable, output clear, output addr, output expected, output read_data);
    modport slave  (input  enable, input  clear, input  addr, input  expected, input  read_data);
endinterface

// File: rtl/sram_result_checker.sv
// SRAM read-back checker: delays {valid, addr, expected} by READ_LATENCY cycles,
// compares against read_data, and records the first failure plus saturating counts.
module sram_result_checker #(
    parameter int ADDR_BITS    = 20,
    parameter int DATA_BITS    = 16,
    parameter int READ_LATENCY = 2,
    parameter int CNT_BITS     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sram_result_checker_if.slave bus,
    output logic                 test_fail,
    output logic [ADDR_BITS-1:0] fail_addr,
    output logic [DATA_BITS-1:0] fail_expected,
    output logic [DATA_BITS-1:0] fail_actual,
    output logic [CNT_BITS-1:0]  error_count,
    output logic [CNT_BITS-1:0]  check_count,
    output logic [1:0]           checker_state
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CHECKING = 2'd1,
        ST_FAILED   = 2'd2
    } state_t;

    // Counters stop at all-ones instead of wrapping.
    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t                  state_q, state_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [ADDR_BITS-1:0]    addr_q [READ_LATENCY];
    logic [ADDR_BITS-1:0]    addr_d [READ_LATENCY];
    logic [DATA_BITS-1:0]    exp_q  [READ_LATENCY];
    logic [DATA_BITS-1:0]    exp_d  [READ_LATENCY];
    logic                    test_fail_q, test_fail_d;
    logic [ADDR_BITS-1:0]    fail_addr_q, fail_addr_d;
    logic [DATA_BITS-1:0]    fail_exp_q, fail_exp_d;
    logic [DATA_BITS-1:0]    fail_act_q, fail_act_d;
    logic [CNT_BITS-1:0]     err_cnt_q, err_cnt_d;
    logic [CNT_BITS-1:0]     chk_cnt_q, chk_cnt_d;
    logic                    cmp_vld;
    logic                    mismatch;
    logic                    pipe_busy;

    // Delay line next-state, compare, result capture and state transitions.
    always_comb begin
        vld_d     = '0;
        vld_d[0]  = bus.enable && !bus.clear;
        addr_d[0] = bus.addr;
        exp_d[0]  = bus.expected;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1] && !bus.clear;
            addr_d[i] = addr_q[i-1];
            exp_d[i]  = exp_q[i-1];
        end

        cmp_vld   = vld_q[READ_LATENCY-1];
        mismatch  = cmp_vld && (bus.read_data != exp_q[READ_LATENCY-1]);
        pipe_busy = |vld_q;

        test_fail_d = test_fail_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_act_d  = fail_act_q;
        err_cnt_d   = err_cnt_q;
        chk_cnt_d   = chk_cnt_q;
        state_d     = state_q;

        if (cmp_vld) chk_cnt_d = sat_inc(chk_cnt_q);
        if (mismatch) begin
            err_cnt_d   = sat_inc(err_cnt_q);
            test_fail_d = 1'b1;
            // Only the first failure is recorded.
            if (!test_fail_q) begin
                fail_addr_d = addr_q[READ_LATENCY-1];
                fail_exp_d  = exp_q[READ_LATENCY-1];
                fail_act_d  = bus.read_data;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (mismatch)                         state_d = ST_FAILED;
                else if (bus.enable || pipe_busy)     state_d = ST_CHECKING;
            end
            ST_CHECKING: begin
                if (mismatch)                         state_d = ST_FAILED;
                else if (!bus.enable && !pipe_busy)   state_d = ST_IDLE;
            end
            ST_FAILED:                                state_d = ST_FAILED;
            default:                                  state_d = ST_IDLE;
        endcase

        // Clear overrides any compare or enable in the same cycle.
        if (bus.clear) begin
            test_fail_d = 1'b0;
            fail_addr_d = '0;
            fail_exp_d  = '0;
            fail_act_d  = '0;
            err_cnt_d   = '0;
            chk_cnt_d   = '0;
            state_d     = ST_IDLE;
        end
    end

    // Control and result registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            vld_q       <= '0;
            test_fail_q <= 1'b0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
            err_cnt_q   <= '0;
            chk_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            vld_q       <= vld_d;
            test_fail_q <= test_fail_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_act_q  <= fail_act_d;
            err_cnt_q   <= err_cnt_d;
            chk_cnt_q   <= chk_cnt_d;
        end
    end

    // Delay-line payload; qualified by vld_q so it needs no reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        exp_q  <= exp_d;
    end

    assign test_fail     = test_fail_q;
    assign fail_addr     = fail_addr_q;
    assign fail_expected = fail_exp_q;
    assign fail_actual   = fail_act_q;
    assign error_count   = err_cnt_q;
    assign check_count   = chk_cnt_q;
    assign checker_state = state_q;

endmodule

// File: tb/tb_sram_result_checker.sv
// Bench for sram_result_checker: directed bursts plus random traffic, checked against
// a transaction-queue reference model; a CNT_BITS=4 instance shares the same bus.
module tb_sram_result_checker;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int L  = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sram_result_checker_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) bus ();

    logic          tf, tf4;
    logic [AW-1:0] fa, fa4;
    logic [DW-1:0] fe, fe4, fact, fact4;
    logic [15:0]   ec, cc;
    logic [3:0]    ec4, cc4;
    logic [1:0]    st, st4;

    sram_result_checker #(.ADDR_BITS(AW), .DATA_BITS(DW), .READ_LATENCY(L), .CNT_BITS(16)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave),
        .test_fail(tf), .fail_addr(fa), .fail_expected(fe), .fail_actual(fact),
        .error_count(ec), .check_count(cc), .checker_state(st));

    sram_result_checker #(.ADDR_BITS(AW), .DATA_BITS(DW), .READ_LATENCY(L), .CNT_BITS(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave),
        .test_fail(tf4), .fail_addr(fa4), .fail_expected(fe4), .fail_actual(fact4),
        .error_count(ec4), .check_count(cc4), .checker_state(st4));

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] e;
        logic [DW-1:0] rd;
        int            due;
    } item_t;

    item_t         q[$];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    logic          m_fail;
    logic [AW-1:0] m_faddr;
    logic [DW-1:0] m_fexp, m_fact;
    int            m_err, m_chk, m_state;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int bits);
        int mx;
        mx = (1 << bits) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_zero();
        q.delete();
        m_fail = 1'b0; m_faddr = '0; m_fexp = '0; m_fact = '0;
        m_err = 0; m_chk = 0; m_state = 0;
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".test_fail"}, 32'(tf), 32'(m_fail));
        check_val({tag, ".fail_addr"}, 32'(fa), 32'(m_faddr));
        check_val({tag, ".fail_exp"}, 32'(fe), 32'(m_fexp));
        check_val({tag, ".fail_act"}, 32'(fact), 32'(m_fact));
        check_val({tag, ".err"}, 32'(ec), 32'(sat(m_err, 16)));
        check_val({tag, ".chk"}, 32'(cc), 32'(sat(m_chk, 16)));
        check_val({tag, ".state"}, 32'(st), 32'(m_state));
        check_val({tag, ".err4"}, 32'(ec4), 32'(sat(m_err, 4)));
        check_val({tag, ".chk4"}, 32'(cc4), 32'(sat(m_chk, 4)));
        check_val({tag, ".test_fail4"}, 32'(tf4), 32'(m_fail));
    endtask

    // One clock: drive inputs, model the edge, then compare 1 ns after the edge.
    task automatic step(input string tag, input logic en, input logic [AW-1:0] a,
                        input logic [DW-1:0] e, input logic bad, input logic [DW-1:0] badv,
                        input logic clr);
        item_t it;
        logic  busy, have, mm;
        busy = (q.size() != 0);
        have = busy && (q[0].due == cyc);
        bus.enable    = en;
        bus.addr      = a;
        bus.expected  = e;
        bus.clear     = clr;
        bus.read_data = have ? q[0].rd : DW'($urandom);
        @(posedge clk);
        mm = 1'b0;
        if (clr) begin
            model_zero();
        end else begin
            if (have) begin
                it = q.pop_front();
                m_chk++;
                if (it.rd != it.e) begin
                    mm = 1'b1;
                    m_err++;
                    if (!m_fail) begin
                        m_fail = 1'b1; m_faddr = it.a; m_fexp = it.e; m_fact = it.rd;
                    end
                end
            end
            if (en) begin
                it.a = a; it.e = e; it.rd = bad ? badv : e; it.due = cyc + L;
                q.push_back(it);
            end
            case (m_state)
                0: if (mm) m_state = 2; else if (en || busy) m_state = 1;
                1: if (mm) m_state = 2; else if (!en && !busy) m_state = 0;
                default: m_state = 2;
            endcase
        end
        cyc++;
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_clear();
        step("clear", 1'b1, AW'(3), DW'(3), 1'b0, '0, 1'b1);
    endtask

    initial begin
        logic [DW-1:0] e, bv;
        model_zero();
        bus.enable = 1'b0; bus.clear = 1'b0; bus.addr = '0;
        bus.expected = '0; bus.read_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset_n = 1'b1;

        // Clean burst of 8, expected = addr.
        for (int i = 0; i < 8; i++) step("burst_ok", 1'b1, AW'(i), DW'(i), 1'b0, '0, 1'b0);
        idle("burst_ok_drain", 5);
        do_clear();

        // Single corruption at address 5.
        for (int i = 0; i < 8; i++)
            step("bad5", 1'b1, AW'(i), DW'(i), (i == 5), 16'hFFFF, 1'b0);
        idle("bad5_drain", 5);
        do_clear();

        // Corruptions at 2 and 6; first one must stick.
        for (int i = 0; i < 8; i++)
            step("bad26", 1'b1, AW'(i), DW'(i), (i == 2 || i == 6), 16'h1234, 1'b0);
        idle("bad26_drain", 5);
        do_clear();

        // Short burst then enable drops; in-flight reads drain.
        for (int i = 0; i < 3; i++) step("short", 1'b1, AW'(i + 40), DW'(i * 7), 1'b0, '0, 1'b0);
        idle("short_drain", 5);
        do_clear();

        // 20 mismatches: 4-bit counter saturates at 15.
        for (int i = 0; i < 20; i++)
            step("sat", 1'b1, AW'(i), DW'(i), 1'b1, ~DW'(i), 1'b0);
        idle("sat_drain", 5);
        do_clear();

        // Clear lands exactly when a mismatching read reaches compare.
        step("clr_hit", 1'b1, AW'(9), DW'(9), 1'b1, 16'h0bad, 1'b0);
        step("clr_hit", 1'b0, '0, '0, 1'b0, '0, 1'b0);
        step("clr_hit", 1'b1, AW'(10), DW'(10), 1'b0, '0, 1'b1);
        idle("clr_hit_after", 4);

        // Asynchronous reset mid-burst with a failure latched.
        for (int i = 0; i < 6; i++)
            step("pre_rst", 1'b1, AW'(i), DW'(i + 100), (i == 1), 16'h0, 1'b0);
        #1;
        bus.enable = 1'b0;
        reset_n = 1'b0;
        #1;
        model_zero();
        check_all("async_rst");
        @(posedge clk);
        cyc++;
        #1;
        reset_n = 1'b1;
        check_all("in_rst");
        idle("post_rst", 4);

        // Random traffic with occasional corruptions and clears.
        for (int i = 0; i < 400; i++) begin
            e  = DW'($urandom);
            bv = e ^ DW'($urandom_range(1, 255));
            step("rand", ($urandom_range(0, 3) != 0), AW'($urandom), e,
                 ($urandom_range(0, 7) == 0), bv, ($urandom_range(0, 39) == 0));
        end
        idle("rand_drain", 5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
